pulse_code_burst_gen: RTL and testbench

Parametrised successor to the single-pulse phase-code generator in the AD9911 signal path. On one GEN request it emits a burst of PULSE_NUM identical-period pulses. Each pulse is a binary phase code of up to CODE_W chips followed by blank chips. It drives the RF DDS amplitude (MA) and phase (MP) profile pins, and adds per-pulse and per-chip strobes, abort, and optional complementary-code alternation.

---
 rtl/pulse_code_burst_gen.sv | 219 +++++++++++++++++++++
 tb/tb_pulse_code_burst_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_code_burst_gen.sv
// pulse_code_burst_gen
//
// Burst generator for binary phase-coded pulses driving the DDS amplitude
// (MA) and phase (MP) profile pins. A GEN request in IDLE latches the code
// words and lengths, then emits PULSE_NUM pulses. Each pulse is made of
// min(CODE_LEN, CODE_W) code chips followed by blank chips, for a total of
// max(PULSE_LEN, code chips, 1) chips. Every chip lasts CHIP_DUR clocks.
//
// Optional feature macro: COMPLEMENT_CODE_EN
//   defined   -> even pulses use CODE_A, odd pulses use CODE_B
//   undefined -> every pulse uses CODE_A; CODE_B is ignored
//
// Ports
//   CLOCK_10M     in   system clock
//   RESET         in   synchronous active-high reset
//   GEN           in   burst request, sampled only in IDLE
//   ABORT         in   terminate the burst at the next edge (beats GEN)
//   RF_OUTPUT_EN  in   combinational gate on MA
//   CODE_A/CODE_B in   phase codes, bit i = chip i
//   CODE_LEN      in   code chips per pulse
//   PULSE_LEN     in   total chips per pulse
//   PULSE_NUM     in   pulses per burst
//   MA            out  amplitude enable (RF_OUTPUT_EN & registered enable)
//   MP            out  phase select, registered
//   GEN_OVER      out  high when idle, low while a burst runs
//   PULSE_SYNC    out  one-cycle strobe on the first cycle of each pulse
//   CHIP_STROBE   out  one-cycle strobe on the first cycle of each chip
//   PULSE_INDEX   out  0-based index of the current pulse
module pulse_code_burst_gen #(
  parameter int CODE_W   = 32,
  parameter int CHIP_DUR = 256
) (
  input  logic              CLOCK_10M,
  input  logic              RESET,
  input  logic              GEN,
  input  logic              ABORT,
  input  logic              RF_OUTPUT_EN,
  input  logic [CODE_W-1:0] CODE_A,
  input  logic [CODE_W-1:0] CODE_B,
  input  logic [7:0]        CODE_LEN,
  input  logic [15:0]       PULSE_LEN,
  input  logic [15:0]       PULSE_NUM,
  output logic              MA,
  output logic              MP,
  output logic              GEN_OVER,
  output logic              PULSE_SYNC,
  output logic              CHIP_STROBE,
  output logic [15:0]       PULSE_INDEX
);

  localparam int               CYC_W    = (CHIP_DUR > 1) ? $clog2(CHIP_DUR) : 1;
  localparam int               IDX_W    = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CHIP_DUR - 1);
  localparam logic [15:0]      CODE_W16 = 16'(CODE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Code chips actually used: CODE_LEN clipped to the code register width.
  function automatic logic [15:0] eff_code_len(input logic [7:0] len);
    logic [15:0] l16;
    l16 = {8'd0, len};
    if (l16 > CODE_W16) return CODE_W16;
    return l16;
  endfunction

  // Pulse length never shorter than its code part and never zero.
  function automatic logic [15:0] eff_pulse_len(input logic [15:0] plen,
                                                input logic [15:0] cl);
    logic [15:0] m;
    m = (plen > cl) ? plen : cl;
    if (m == 16'd0) m = 16'd1;
    return m;
  endfunction

  state_t            r_state;
  logic [CODE_W-1:0] r_code_a;
  logic [15:0]       r_cl;
  logic [15:0]       r_pl;
  logic [15:0]       r_num;
  logic [CYC_W-1:0]  r_cyc;
  logic [15:0]       r_chip;
  logic [15:0]       r_pulse;
  logic              r_fin;
  logic              r_ma;
  logic              r_mp;
  logic              r_gen_over;
  logic              r_psync;
  logic              r_cstrobe;
  logic [15:0]       r_pidx;

  logic [15:0]       w_cl;
  logic [15:0]       w_pl;
  logic [CODE_W-1:0] w_code;
  logic              w_in_code;
  logic              w_code_bit;
  logic              w_chip_start;
  logic              w_pulse_start;

`ifdef COMPLEMENT_CODE_EN
  logic [CODE_W-1:0] r_code_b;

  always_ff @(posedge CLOCK_10M) begin
    if (r_state == S_IDLE && GEN && !ABORT && !RESET) r_code_b <= CODE_B;
  end

  // Complementary pair: odd pulses sound the second code.
  assign w_code = r_pulse[0] ? r_code_b : r_code_a;
`else
  logic w_unused_code_b;
  assign w_unused_code_b = ^CODE_B;
  assign w_code          = r_code_a;
`endif

  assign w_cl          = eff_code_len(CODE_LEN);
  assign w_pl          = eff_pulse_len(PULSE_LEN, w_cl);
  assign w_in_code     = (r_chip < r_cl);
  // Index is only meaningful while w_in_code, where r_chip < CODE_W.
  assign w_code_bit    = w_code[r_chip[IDX_W-1:0]];
  assign w_chip_start  = (r_cyc == '0);
  assign w_pulse_start = w_chip_start && (r_chip == 16'd0);

  // Code word and lengths are data: loaded on acceptance, never reset.
  always_ff @(posedge CLOCK_10M) begin
    if (r_state == S_IDLE && GEN && !ABORT && !RESET) begin
      r_code_a <= CODE_A;
      r_cl     <= w_cl;
      r_pl     <= w_pl;
      r_num    <= PULSE_NUM;
    end
  end

  // Counters (r_cyc, r_chip, r_pulse) describe the chip whose outputs are
  // registered at the next RUN edge. r_fin marks that the last chip has been
  // issued, so the following edge clears MA/MP and enters DONE; DONE then
  // raises GEN_OVER one edge later.
  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_chip     <= 16'd0;
      r_pulse    <= 16'd0;
      r_fin      <= 1'b0;
      r_ma       <= 1'b0;
      r_mp       <= 1'b0;
      r_gen_over <= 1'b1;
      r_psync    <= 1'b0;
      r_cstrobe  <= 1'b0;
      r_pidx     <= 16'd0;
    end else if (ABORT) begin
      r_state    <= S_IDLE;
      r_fin      <= 1'b0;
      r_ma       <= 1'b0;
      r_mp       <= 1'b0;
      r_gen_over <= 1'b1;
      r_psync    <= 1'b0;
      r_cstrobe  <= 1'b0;
      r_pidx     <= 16'd0;
    end else begin
      r_psync   <= 1'b0;
      r_cstrobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (GEN) begin
            r_cyc      <= '0;
            r_chip     <= 16'd0;
            r_pulse    <= 16'd0;
            r_fin      <= 1'b0;
            r_gen_over <= 1'b0;
            r_state    <= (PULSE_NUM == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (r_fin) begin
            r_ma    <= 1'b0;
            r_mp    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_ma      <= w_in_code;
            r_mp      <= w_in_code & w_code_bit;
            r_cstrobe <= w_chip_start;
            r_psync   <= w_pulse_start;
            if (w_pulse_start) r_pidx <= r_pulse;
            if (r_cyc == CYC_LAST) begin
              r_cyc <= '0;
              if (r_chip == r_pl - 16'd1) begin
                r_chip <= 16'd0;
                if (r_pulse == r_num - 16'd1) r_fin <= 1'b1;
                else                          r_pulse <= r_pulse + 16'd1;
              end else begin
                r_chip <= r_chip + 16'd1;
              end
            end else begin
              r_cyc <= r_cyc + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_ma       <= 1'b0;
          r_mp       <= 1'b0;
          r_gen_over <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MA          = RF_OUTPUT_EN & r_ma;
  assign MP          = r_mp;
  assign GEN_OVER    = r_gen_over;
  assign PULSE_SYNC  = r_psync;
  assign CHIP_STROBE = r_cstrobe;
  assign PULSE_INDEX = r_pidx;

endmodule

// File: tb/tb_pulse_code_burst_gen.sv
// Testbench for pulse_code_burst_gen with CHIP_DUR=4, CODE_W=32.
// Burst vectors come from a table; the expected per-cycle output stream of
// each burst is pushed to a scoreboard queue when GEN is driven and popped
// one entry per clock. Abort and mid-burst reset are hand-written sequences.
module tb_pulse_code_burst_gen;

  localparam int CD = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          RESET;
  logic          GEN;
  logic          ABORT;
  logic          RF_OUTPUT_EN;
  logic [CW-1:0] CODE_A;
  logic [CW-1:0] CODE_B;
  logic [7:0]    CODE_LEN;
  logic [15:0]   PULSE_LEN;
  logic [15:0]   PULSE_NUM;
  logic          MA;
  logic          MP;
  logic          GEN_OVER;
  logic          PULSE_SYNC;
  logic          CHIP_STROBE;
  logic [15:0]   PULSE_INDEX;

  pulse_code_burst_gen #(.CODE_W(CW), .CHIP_DUR(CD)) dut (
    .CLOCK_10M    (clk),
    .RESET        (RESET),
    .GEN          (GEN),
    .ABORT        (ABORT),
    .RF_OUTPUT_EN (RF_OUTPUT_EN),
    .CODE_A       (CODE_A),
    .CODE_B       (CODE_B),
    .CODE_LEN     (CODE_LEN),
    .PULSE_LEN    (PULSE_LEN),
    .PULSE_NUM    (PULSE_NUM),
    .MA           (MA),
    .MP           (MP),
    .GEN_OVER     (GEN_OVER),
    .PULSE_SYNC   (PULSE_SYNC),
    .CHIP_STROBE  (CHIP_STROBE),
    .PULSE_INDEX  (PULSE_INDEX)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] code_a;
    logic [31:0] code_b;
    logic [7:0]  code_len;
    logic [15:0] pulse_len;
    logic [15:0] pulse_num;
    int          exp_cl;
    int          exp_pl;
    int          exp_low;
    bit          en_toggle;
    bit          gen_hold;
  } vec_t;

  vec_t        vecs[6];
  logic [20:0] sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] prev_pi  = 16'd0;

  function automatic logic [20:0] pack(input logic ma, input logic mp, input logic go,
                                       input logic ps, input logic cs, input logic [15:0] pi);
    return {ma, mp, go, ps, cs, pi};
  endfunction

  function automatic logic [20:0] cur();
    return {MA, MP, GEN_OVER, PULSE_SYNC, CHIP_STROBE, PULSE_INDEX};
  endfunction

  function automatic bit en_pat(input bit toggle, input int j);
    return toggle ? (j % 5 != 2) : 1'b1;
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got ma=%b mp=%b go=%b ps=%b cs=%b pi=%0d, required ma=%b mp=%b go=%b ps=%b cs=%b pi=%0d",
               name, $time, act[20], act[19], act[18], act[17], act[16], act[15:0],
               exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected output of every cycle from the GEN edge (j=0) until
  // GEN_OVER is back high.
  task automatic push_expected(input vec_t v);
    int n, cl, pl, plen_cyc, total, t, p, rem, c, cy;
    logic [31:0] code;
    logic ma, mp;
    logic [15:0] last_pi;
    n = int'(v.pulse_num);
    cl = v.exp_cl;
    pl = v.exp_pl;
    plen_cyc = pl * CD;
    total = (n == 0) ? 1 : n * plen_cyc + 2;
    last_pi = (n == 0) ? prev_pi : 16'(n - 1);
    for (int j = 0; j <= total; j++) begin
      t = j - 1;
      if (j == 0) begin
        sb.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, prev_pi));
      end else if (n == 0) begin
        sb.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, prev_pi));
      end else if (t < n * plen_cyc) begin
        p   = t / plen_cyc;
        rem = t % plen_cyc;
        c   = rem / CD;
        cy  = rem % CD;
        code = v.code_a;
`ifdef COMPLEMENT_CODE_EN
        if (p % 2 == 1) code = v.code_b;
`endif
        ma = (c < cl);
        mp = 1'b0;
        if (ma) mp = code[c];
        sb.push_back(pack(ma & en_pat(v.en_toggle, j), mp, 1'b0, (rem == 0), (cy == 0), 16'(p)));
      end else if (t == n * plen_cyc) begin
        sb.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_pi));
      end else begin
        sb.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, last_pi));
      end
    end
    prev_pi = last_pi;
  endtask

  task automatic run_burst(input vec_t v, input string name);
    int low_cnt;
    logic [20:0] exp;
    CODE_A    = v.code_a;
    CODE_B    = v.code_b;
    CODE_LEN  = v.code_len;
    PULSE_LEN = v.pulse_len;
    PULSE_NUM = v.pulse_num;
    GEN       = 1'b1;
    push_expected(v);
    low_cnt = 0;
    for (int j = 0; sb.size() > 0; j++) begin
      @(posedge clk);
      RF_OUTPUT_EN = en_pat(v.en_toggle, j);
      #1;
      exp = sb.pop_front();
      check(name, cur(), exp);
      if (!GEN_OVER) low_cnt++;
      // Scramble inputs after acceptance: the burst must run on latched values.
      CODE_A    = ~v.code_a;
      CODE_B    = ~v.code_b;
      CODE_LEN  = v.code_len + 8'd1;
      PULSE_LEN = v.pulse_len + 16'd3;
      PULSE_NUM = v.pulse_num + 16'd1;
      GEN       = v.gen_hold && (j >= 3) && (j <= 6);
    end
    GEN          = 1'b0;
    RF_OUTPUT_EN = 1'b1;
    check_int({name, "_gen_over_low"}, low_cnt, v.exp_low);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mp_p1;
    vecs[0] = '{32'h0000_000B, 32'h0000_0004, 8'd4,  16'd6,  16'd2, 4,  6,  50,  1'b0, 1'b0};
    vecs[1] = '{32'hA5C3_1E69, 32'h0000_0000, 8'd40, 16'd10, 16'd1, 32, 32, 130, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_00FF, 32'h0000_00FF, 8'd4,  16'd6,  16'd0, 4,  6,  1,   1'b0, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0002, 8'd3,  16'd1,  16'd3, 3,  3,  38,  1'b0, 1'b1};
    vecs[4] = '{32'h0000_0001, 32'h0000_0001, 8'd0,  16'd0,  16'd2, 0,  1,  10,  1'b0, 1'b0};
    vecs[5] = '{32'h0000_000B, 32'h0000_0004, 8'd4,  16'd6,  16'd2, 4,  6,  50,  1'b1, 1'b0};

    RESET = 1'b1; GEN = 1'b0; ABORT = 1'b0; RF_OUTPUT_EN = 1'b1;
    CODE_A = '0; CODE_B = '0; CODE_LEN = 8'd0; PULSE_LEN = 16'd0; PULSE_NUM = 16'd0;
    repeat (3) step();
    check("reset_state", cur(), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    RESET = 1'b0;
    step();
    check("idle_after_reset", cur(), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));

    for (int i = 0; i < 6; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

    // Abort inside the third chip of pulse 0 (all-ones code, so MP is high).
    CODE_A = 32'hF; CODE_B = 32'hF; CODE_LEN = 8'd4; PULSE_LEN = 16'd6; PULSE_NUM = 16'd2;
    GEN = 1'b1;
    step();
    check("abort_accept", cur(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, prev_pi));
    GEN = 1'b0;
    repeat (10) step();
    check("abort_chip2", cur(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    ABORT = 1'b1;
    step();
    check("abort_next_edge", cur(), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    ABORT = 1'b0;
    prev_pi = 16'd0;
    step();
    check("abort_idle", cur(), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    run_burst(vecs[0], "after_abort");

    // Reset in pulse 1 of a running burst.
    CODE_A = vecs[0].code_a; CODE_B = vecs[0].code_b; CODE_LEN = 8'd4;
    PULSE_LEN = 16'd6; PULSE_NUM = 16'd2;
    GEN = 1'b1;
    step();
    GEN = 1'b0;
    repeat (26) step();
    mp_p1 = 1'b1;
`ifdef COMPLEMENT_CODE_EN
    mp_p1 = 1'b0;
`endif
    check("rst_pre_pulse1", cur(), pack(1'b1, mp_p1, 1'b0, 1'b0, 1'b0, 16'd1));
    RESET = 1'b1;
    step();
    check("rst_midburst", cur(), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    RESET = 1'b0;
    prev_pi = 16'd0;
    step();
    check("rst_idle", cur(), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    run_burst(vecs[3], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
